// File: rtl/rom_refill_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rom_refill_arbiter
// Brief    : Round-robin arbiter sharing one combinational ROM between the
//            I-cache and D-cache refill ports; critical-word-first wrapped
//            line bursts returned on registered valid/data/last streams.
// Revision : 1.0 - initial release
// ============================================================================
module rom_refill_arbiter #(
    parameter int LINE_WORDS  = 4,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ic_req,
    input  logic [15:0] ic_addr,
    output logic        ic_ack,
    output logic        ic_rvalid,
    output logic [31:0] ic_rdata,
    output logic        ic_last,
    input  logic        dc_req,
    input  logic [15:0] dc_addr,
    output logic        dc_ack,
    output logic        dc_rvalid,
    output logic [31:0] dc_rdata,
    output logic        dc_last,
    output logic [15:0] rom_addr,
    input  logic [31:0] rom_data,
    output logic        busy
);

    localparam int c_idx_w  = $clog2(LINE_WORDS);
    localparam int c_wait_w = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    localparam logic [15:0]         c_line_mask = 16'(LINE_WORDS * 4 - 1);
    localparam logic [c_idx_w-1:0]  c_n_last    = c_idx_w'(LINE_WORDS - 1);
    localparam logic [c_wait_w-1:0] c_wait_last = c_wait_w'(WAIT_CYCLES - 1);

    localparam logic [0:0] c_st_idle   = 1'b0;
    localparam logic [0:0] c_st_access = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_nxt;
    logic                r_prio_dc;
    logic                r_gnt_dc;
    logic [15:0]         r_base;
    logic [c_idx_w-1:0]  r_idx;
    logic [c_idx_w-1:0]  r_n;
    logic [c_wait_w-1:0] r_wait;

    logic                r_ic_ack;
    logic                r_ic_rvalid;
    logic [31:0]         r_ic_rdata;
    logic                r_ic_last;
    logic                r_dc_ack;
    logic                r_dc_rvalid;
    logic [31:0]         r_dc_rdata;
    logic                r_dc_last;

    logic                w_grant_ic;
    logic                w_grant_dc;
    logic                w_sample;
    logic                w_final;
    logic [15:0]         w_req_addr;
    logic [c_idx_w-1:0]  w_word_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_st_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_grant_ic  = 1'b0;
        w_grant_dc  = 1'b0;
        w_sample    = 1'b0;
        w_final     = 1'b0;
        case (r_state)
            c_st_idle: begin
                // Contention is resolved by the priority pointer; a lone requester always wins.
                if (ic_req && dc_req) begin
                    w_grant_dc = r_prio_dc;
                    w_grant_ic = !r_prio_dc;
                end else begin
                    w_grant_ic = ic_req;
                    w_grant_dc = dc_req;
                end
                if (ic_req || dc_req) begin
                    w_state_nxt = c_st_access;
                end
            end
            c_st_access: begin
                w_sample = (r_wait == c_wait_last);
                w_final  = w_sample && (r_n == c_n_last);
                if (w_final) begin
                    w_state_nxt = c_st_idle;
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    assign w_req_addr = w_grant_dc ? dc_addr : ic_addr;
    // Index arithmetic is c_idx_w bits wide, so the burst wraps inside the line.
    assign w_word_idx = r_idx + r_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_prio_dc   <= 1'b0;
            r_gnt_dc    <= 1'b0;
            r_base      <= 16'h0000;
            r_idx       <= '0;
            r_n         <= '0;
            r_wait      <= '0;
            r_ic_ack    <= 1'b0;
            r_ic_rvalid <= 1'b0;
            r_ic_rdata  <= 32'h0;
            r_ic_last   <= 1'b0;
            r_dc_ack    <= 1'b0;
            r_dc_rvalid <= 1'b0;
            r_dc_rdata  <= 32'h0;
            r_dc_last   <= 1'b0;
        end else begin
            r_ic_ack    <= w_grant_ic;
            r_dc_ack    <= w_grant_dc;
            r_ic_rvalid <= w_sample && !r_gnt_dc;
            r_dc_rvalid <= w_sample && r_gnt_dc;
            r_ic_last   <= w_final && !r_gnt_dc;
            r_dc_last   <= w_final && r_gnt_dc;
            if (w_sample && !r_gnt_dc) begin
                r_ic_rdata <= rom_data;
            end
            if (w_sample && r_gnt_dc) begin
                r_dc_rdata <= rom_data;
            end
            if (w_grant_ic || w_grant_dc) begin
                r_gnt_dc  <= w_grant_dc;
                r_prio_dc <= w_grant_ic;
                r_base    <= w_req_addr & ~c_line_mask;
                r_idx     <= w_req_addr[c_idx_w+1:2];
                r_n       <= '0;
                r_wait    <= '0;
            end else if (r_state == c_st_access) begin
                if (w_sample) begin
                    r_wait <= '0;
                    r_n    <= r_n + 1'b1;
                end else begin
                    r_wait <= r_wait + 1'b1;
                end
            end
        end
    end

    assign rom_addr  = (r_state == c_st_access) ?
                       (r_base | {{(14 - c_idx_w){1'b0}}, w_word_idx, 2'b00}) : 16'h0000;
    assign busy      = (r_state == c_st_access);
    assign ic_ack    = r_ic_ack;
    assign ic_rvalid = r_ic_rvalid;
    assign ic_rdata  = r_ic_rdata;
    assign ic_last   = r_ic_last;
    assign dc_ack    = r_dc_ack;
    assign dc_rvalid = r_dc_rvalid;
    assign dc_rdata  = r_dc_rdata;
    assign dc_last   = r_dc_last;

endmodule
`default_nettype wire

// File: doc/rom_refill_arbiter.md
Name: rom_refill_arbiter

Overview:
- Shares the single combinational-read instruction/constant ROM between the I-cache and D-cache refill ports of the pipelined CPU.
- Arbitrates line-refill requests round-robin and sequences one LINE_WORDS-word burst per grant, critical word first with wrap inside the line.
- Returns words to the granted cache through a registered valid/data/last stream.
- Sits between the two cache miss handlers and the ROM address/data pins.

Parameters:
- LINE_WORDS, 4, words per cache line; power of two, 2..16.
- WAIT_CYCLES, 1, cycles rom_addr is held per word before rom_data is sampled; >=1.

Ports:
- clk  in  1  system clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- ic_req  in  1  I-cache refill request; held until ic_ack
- ic_addr  in  16  I-cache miss byte address, bits[1:0] ignored
- ic_ack  out  1  one-cycle pulse: I-cache request granted
- ic_rvalid  out  1  ic_rdata valid this cycle
- ic_rdata  out  32  refill word
- ic_last  out  1  with ic_rvalid: final word of burst
- dc_req  in  1  D-cache refill request; same rules as ic_req
- dc_addr  in  16  D-cache miss byte address
- dc_ack  out  1  grant pulse
- dc_rvalid  out  1  data valid
- dc_rdata  out  32  refill word
- dc_last  out  1  final word flag
- rom_addr  out  16  ROM byte address, always word-aligned
- rom_data  in  32  ROM read data, combinational from rom_addr
- busy  out  1  high while state is ACCESS

Behaviour:
- Reset:
  - Decided: one clock; reset is synchronous and active-high.
  - On rst, every output is 0, state goes to IDLE, and priority points to I-cache.
  - Reset mid-burst aborts the burst: no further rvalid/last, and no ack until requests are re-sampled in IDLE.
- States: IDLE, ACCESS.
- IDLE:
  - rom_addr=0, busy=0.
  - If any req is high, the grant goes to the single requester. If both are high, it goes to the priority holder.
  - On grant, latch the selected address:
    - base = addr & ~(LINE_WORDS*4-1)
    - start_idx = addr[log2(LINE_WORDS)+1:2]
  - Pulse the matching ack in the next cycle and enter ACCESS.
  - Priority then flips to the other requester.
- ACCESS:
  - rom_addr = base | (((start_idx+n) mod LINE_WORDS) << 2), where n is the word count 0..LINE_WORDS-1.
  - wait_cnt counts 0..WAIT_CYCLES-1. In its final cycle, rom_data is registered into the granted rdata and that rvalid is set for the next cycle. Then n increments and wait_cnt clears.
  - The sample of word n=LINE_WORDS-1 also sets last alongside rvalid, and the next state is IDLE.
- Outputs:
  - rvalid and last are single-cycle pulses.
  - rdata holds its last value when rvalid=0.
  - The non-granted port's outputs stay 0.
- Latency, WAIT_CYCLES=1, req sampled in cycle 0:
  - ack at cycle 1.
  - rvalid at cycles 2..LINE_WORDS+1.
  - last at cycle LINE_WORDS+1, which is also the first IDLE cycle.
  - The earliest next ack is LINE_WORDS+2.
- Burst length is LINE_WORDS*WAIT_CYCLES cycles in ACCESS.
- Wrap: addresses never carry out of the line. For example, 0xFFF8 with LINE_WORDS=4 reads 0xFFF8, 0xFFFC, 0xFFF0, 0xFFF4.
- Request changes:
  - A req dropped before ack is treated as withdrawn.
  - req changes during ACCESS are ignored.
  - A requester that keeps req high after last is re-arbitrated in IDLE.
- A requester receiving a burst cannot be re-granted before the other pending requester, because priority alternates.

Test Plan:
- Reset, then ic_req=1 with ic_addr=0x0100, WAIT_CYCLES=1 -> ic_ack at cycle 1; rom_addr 0x100, 0x104, 0x108, 0x10C; ic_rvalid cycles 2-5 carrying ROM words; ic_last only at cycle 5; dc_* stay 0.
- dc_req with dc_addr=0x0108 -> rom_addr order 0x108, 0x10C, 0x100, 0x104; dc_rdata matches each; address 0xFFFA yields 0xFFF8, 0xFFFC, 0xFFF0, 0xFFF4.
- ic_req and dc_req both high from reset, held -> I-cache is served first, then D-cache, then I-cache; acks are strictly alternating with one IDLE cycle between bursts.
- WAIT_CYCLES=3 -> each rom_addr is stable 3 cycles; rvalid spacing is 3 cycles; busy is high for 12 cycles.
- rst asserted during the 2nd word -> next cycle all outputs 0 and state IDLE; no last pulse; a held request re-acks after rst deasserts.
- req pulse dropped while the other burst is in progress -> no ack is ever issued for it.
